demux_tl: RTL
=============

Name: demux_tl

Overview:
- Receive-side counterpart of the 4-lane transaction-layer mux.
- Accepts one 10-bit word stream from the link side and steers each word to one of four virtual-channel outputs using destination bits [9:8].
- Each output has a one-entry registered holding stage with a valid/ready handshake toward the per-VC FIFOs.
- Input is accepted only while the controller state equals the active code; drain continues in any state.

Parameters:
- DATA_W, 10, word width; bits [DATA_W-1:DATA_W-2] are the destination select.
- ACTIVE_STATE, 4'b0100, state code in which new words are accepted.

Ports:
- clk  input  1  system clock, rising edge.
- reset_L  input  1  asynchronous active-low reset.
- state  input  4  controller state code.
- in_data  input  DATA_W  incoming word.
- in_valid  input  1  in_data holds a word.
- in_ready  output  1  block accepts in_data this cycle.
- out0..out3  output  DATA_W each  holding-register contents for VC0..VC3.
- valid0..valid3  output  1 each  holding register n full.
- ready0..ready3  input  1 each  downstream VC n takes outn this cycle.
- idle  output  1  all holding registers empty and in_valid low.
- route_cnt  output  8  total words accepted, wraps 255->0.

Behaviour:
- Reset (reset_L=0, asynchronous): out0..3=0, valid0..3=0, route_cnt=0. Reset asserted mid-transfer discards all held words; no partial word is ever presented.
- dest = in_data[DATA_W-1:DATA_W-2]: 00->VC0, 01->VC1, 10->VC2, 11->VC3.
- Output transfer on VC n: valid_n && ready_n at a rising edge.
- in_ready = (state==ACTIVE_STATE) && (!valid_dest || ready_dest). This is combinational on in_data, state and ready_dest. in_ready is meaningless while in_valid=0 but follows the same equation.
- Input acceptance: in_valid && in_ready at a rising edge.
- On acceptance, the word is loaded into holding register dest. valid_dest is 1 the next cycle; latency is 1 clock from acceptance to outn.
- Simultaneous drain and load on the same VC: the new word replaces the old in the same edge and valid stays 1, giving full throughput of 1 word/cycle per VC.
- Drain with no load on VC n: valid_n -> 0; outn holds its last value.
- Load on VC a and drain on VC b (a!=b) in the same cycle are independent.
- Only one VC can be loaded per cycle.
- state != ACTIVE_STATE: no new words are accepted; held words still drain normally. A state change while a word is held never drops it.
- outn is stable while valid_n=1 and ready_n=0. Backpressure is per VC: a stalled VC blocks the input only when the current word targets that VC (head-of-line blocking is intended; there is no reordering).
- route_cnt increments by 1 on each acceptance and wraps modulo 256.
- idle = !(valid0|valid1|valid2|valid3) && !in_valid, combinational.
- No X propagation: when reset_L=1, every output is driven from a reset flop or from a defined combinational term.

Test Plan:
- Reset check: hold reset_L=0 for 2 cycles with in_valid=1 -> all valid=0, out=0, route_cnt=0, idle=0. Release with in_valid=0 -> idle=1.
- Routing: state=4'b0100, all ready=1, send 10'h0AA, 10'h155, 10'h2CC, 10'h3F0 on consecutive cycles -> each appears one cycle later on out0/out1/out2/out3 respectively with only that valid high; route_cnt=4.
- Backpressure: ready1=0, send 10'h111 then 10'h122 (both VC1) -> out1=10'h111 held, valid1=1, in_ready=0 for the second word. Raise ready1 -> same-edge swap, out1=10'h122, valid1 stays 1.
- Non-blocking: with VC1 stalled and full, send 10'h0AB (VC0) -> accepted, out0=10'h0AB next cycle, VC1 unchanged.
- State gating: load 10'h333 into VC3, set state=4'b0010 with in_valid=1 -> in_ready=0, no acceptance; with ready3=1, VC3 drains and valid3=0; route_cnt unchanged.
- Wrap and reset mid-operation: accept 256 words -> route_cnt=0. Then load VC0 and VC2, pulse reset_L low mid-cycle -> valids clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/demux_tl.sv
// demux_tl: steers a single link-side word stream into four registered
// virtual-channel holding stages by destination bits, with per-VC valid/ready.
module demux_tl #(
    parameter int          DATA_W       = 10,
    parameter logic [3:0]  ACTIVE_STATE = 4'b0100
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [3:0]        state,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic              valid0,
    output logic              valid1,
    output logic              valid2,
    output logic              valid3,
    input  logic              ready0,
    input  logic              ready1,
    input  logic              ready2,
    input  logic              ready3,
    output logic              idle,
    output logic [7:0]        route_cnt
);
    logic [DATA_W-1:0] r_data [4];
    logic [3:0]        r_valid;
    logic [7:0]        r_cnt;
    logic [1:0]        w_dest;
    logic [3:0]        w_rdy;
    logic [3:0]        w_load;
    logic              w_accept;

    assign w_dest   = in_data[DATA_W-1 -: 2];
    assign w_rdy    = {ready3, ready2, ready1, ready0};
    // Head-of-line: only the VC the current word targets can stall the input.
    assign in_ready = (state == ACTIVE_STATE) && (!r_valid[w_dest] || w_rdy[w_dest]);
    assign w_accept = in_valid && in_ready;

    for (genvar g = 0; g < 4; g++) begin : g_vc
        assign w_load[g] = w_accept && (w_dest == 2'(g));
        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                r_data[g]  <= '0;
                r_valid[g] <= 1'b0;
            end else if (w_load[g]) begin
                r_data[g]  <= in_data;
                r_valid[g] <= 1'b1;
            end else if (w_rdy[g]) begin
                r_valid[g] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) r_cnt <= '0;
        else if (w_accept) r_cnt <= r_cnt + 8'd1;
    end

    assign out0      = r_data[0];
    assign out1      = r_data[1];
    assign out2      = r_data[2];
    assign out3      = r_data[3];
    assign valid0    = r_valid[0];
    assign valid1    = r_valid[1];
    assign valid2    = r_valid[2];
    assign valid3    = r_valid[3];
    assign idle      = ~|r_valid && !in_valid;
    assign route_cnt = r_cnt;
endmodule
